// File: rtl/rs_pkg.sv
// Shared types and helpers for the ALU reservation station.
// Defining RS_AGE_ISSUE_EN adds a per-entry sequence stamp for oldest-first issue.
package rs_pkg;

  localparam int unsigned OpW       = 4;
  // Entry fields are sized for the widest supported configuration.
  localparam int unsigned RobWMax   = 8;
  localparam int unsigned StampWMax = 9;

  typedef enum logic [OpW-1:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpXor = 4'd2,
    OpOr  = 4'd3,
    OpAnd = 4'd4,
    OpSll = 4'd5,
    OpSrl = 4'd6,
    OpSra = 4'd7,
    OpEq  = 4'd8,
    OpNe  = 4'd9,
    OpLt  = 4'd10,
    OpLtu = 4'd11
  } alu_op_e;

  // Lowest bit of port p's slice in a flattened CDB bus of per-port width w.
  function automatic int cdb_lsb(input int port, input int width);
    return port * width;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [RobWMax-1:0] rob_index;
    logic [OpW-1:0]     op;
    logic [31:0]        value1;
    logic [31:0]        value2;
    logic               has_dep1;
    logic               has_dep2;
    logic [RobWMax-1:0] constrt1;
    logic [RobWMax-1:0] constrt2;
`ifdef RS_AGE_ISSUE_EN
    logic [StampWMax-1:0] stamp;
`endif
  } rs_entry_t;

endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU used by the reservation station execute stage.
module rs_alu
  import rs_pkg::*;
#(
  parameter int unsigned RS_OP_WIDTH = 4
) (
  input  logic [RS_OP_WIDTH-1:0] op_i,
  input  logic [31:0]            v1_i,
  input  logic [31:0]            v2_i,
  output logic [31:0]            result_o
);

  logic [4:0] shamt;
  assign shamt = v2_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      OpAdd:   result_o = v1_i + v2_i;
      OpSub:   result_o = v1_i - v2_i;
      OpXor:   result_o = v1_i ^ v2_i;
      OpOr:    result_o = v1_i | v2_i;
      OpAnd:   result_o = v1_i & v2_i;
      OpSll:   result_o = v1_i << shamt;
      OpSrl:   result_o = v1_i >> shamt;
      OpSra:   result_o = $unsigned($signed(v1_i) >>> shamt);
      OpEq:    result_o = {31'b0, v1_i == v2_i};
      OpNe:    result_o = {31'b0, v1_i != v2_i};
      OpLt:    result_o = {31'b0, $signed(v1_i) < $signed(v2_i)};
      OpLtu:   result_o = {31'b0, v1_i < v2_i};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station with multi-port CDB wakeup, EX/WB pipeline and valid/ready output.
// Optional RS_AGE_ISSUE_EN: oldest ready entry issues instead of lowest index.
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned RS_OP_WIDTH = 4,
  parameter int unsigned RS_WIDTH    = 4,
  parameter int unsigned ROB_WIDTH   = 4,
  parameter int unsigned CDB_PORTS   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           add_valid_i,
  input  logic [RS_OP_WIDTH-1:0]         add_op_i,
  input  logic [ROB_WIDTH-1:0]           add_rob_index_i,
  input  logic [31:0]                    add_val1_i,
  input  logic [31:0]                    add_val2_i,
  input  logic                           add_has_dep1_i,
  input  logic                           add_has_dep2_i,
  input  logic [ROB_WIDTH-1:0]           add_constrt1_i,
  input  logic [ROB_WIDTH-1:0]           add_constrt2_i,
  output logic                           full_o,
  input  logic [CDB_PORTS-1:0]           cdb_valid_i,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_rob_id_i,
  input  logic [CDB_PORTS*32-1:0]        cdb_val_i,
  output logic                           update_valid_o,
  input  logic                           update_ready_i,
  output logic [ROB_WIDTH-1:0]           update_rob_id_o,
  output logic [31:0]                    update_val_o
);

  localparam int unsigned Depth = 2 ** RS_WIDTH;
  localparam int unsigned OccW  = RS_WIDTH + 1;

  rs_entry_t entry_q [Depth];
  rs_entry_t entry_d [Depth];
  rs_entry_t new_entry;

  logic [OccW-1:0]        occ_q, occ_d;
  logic [Depth-1:0]       ready;
  logic                   sel_found;
  logic [RS_WIDTH-1:0]    sel_idx, free_idx;
  logic                   do_insert, do_issue, wb_free, ex_free, self_wake;

  logic                   ex_valid_q, ex_valid_d;
  logic [RS_OP_WIDTH-1:0] ex_op_q, ex_op_d;
  logic [31:0]            ex_v1_q, ex_v1_d, ex_v2_q, ex_v2_d;
  logic [ROB_WIDTH-1:0]   ex_rob_q, ex_rob_d;
  logic [31:0]            alu_result;
  logic                   wb_valid_q, wb_valid_d;
  logic [ROB_WIDTH-1:0]   wb_rob_q, wb_rob_d;
  logic [31:0]            wb_val_q, wb_val_d;

  assign full_o          = (occ_q == OccW'(Depth));
  assign update_valid_o  = wb_valid_q;
  assign update_rob_id_o = wb_rob_q;
  assign update_val_o    = wb_val_q;
  assign self_wake       = wb_valid_q && update_ready_i;

  assign wb_free   = !wb_valid_q || update_ready_i;
  assign ex_free   = !ex_valid_q || wb_free;
  assign do_insert = add_valid_i && !full_o && !flush_i;
  assign do_issue  = sel_found && ex_free && !flush_i;

  // Returns {still_pending, value}; the self port is applied last so it wins over any CDB port,
  // and ports are scanned high to low so the lowest matching port wins among them.
  function automatic logic [32:0] wake(input logic dep, input logic [ROB_WIDTH-1:0] tag,
                                       input logic [31:0] val);
    logic [32:0] r;
    r = {dep, val};
    if (dep) begin
      for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
        if (cdb_valid_i[p] && cdb_rob_id_i[cdb_lsb(p, int'(ROB_WIDTH)) +: ROB_WIDTH] == tag) begin
          r = {1'b0, cdb_val_i[cdb_lsb(p, 32) +: 32]};
        end
      end
      if (self_wake && wb_rob_q == tag) r = {1'b0, wb_val_q};
    end
    return r;
  endfunction

`ifdef RS_AGE_ISSUE_EN
  localparam int unsigned StampW = RS_WIDTH + 1;
  logic [StampW-1:0] seq_q, seq_d;

  // Modular age compare: safe because live stamps never span more than Depth inserts.
  function automatic logic older(input logic [StampW-1:0] a, input logic [StampW-1:0] b);
    logic [StampW-1:0] diff;
    diff = a - b;
    return diff[StampW-1];
  endfunction

  assign seq_d = flush_i ? '0 : seq_q + StampW'(do_insert);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) seq_q <= '0;
    else         seq_q <= seq_d;
  end
`endif

  always_comb begin
    ready     = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      ready[i] = entry_q[i].valid && !entry_q[i].has_dep1 && !entry_q[i].has_dep2;
    end
    for (int i = int'(Depth) - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) free_idx = RS_WIDTH'(i);
    end
`ifdef RS_AGE_ISSUE_EN
    for (int i = 0; i < int'(Depth); i++) begin
      if (ready[i] && (!sel_found ||
          older(entry_q[i].stamp[StampW-1:0], entry_q[sel_idx].stamp[StampW-1:0]))) begin
        sel_found = 1'b1;
        sel_idx   = RS_WIDTH'(i);
      end
    end
`else
    for (int i = int'(Depth) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = RS_WIDTH'(i);
      end
    end
`endif
  end

  always_comb begin
    logic [32:0] w1, w2;
    w1 = wake(add_has_dep1_i, add_constrt1_i, add_val1_i);
    w2 = wake(add_has_dep2_i, add_constrt2_i, add_val2_i);
    new_entry                               = '0;
    new_entry.valid                         = 1'b1;
    new_entry.rob_index[ROB_WIDTH-1:0]      = add_rob_index_i;
    new_entry.op                            = add_op_i;
    new_entry.value1                        = w1[31:0];
    new_entry.value2                        = w2[31:0];
    new_entry.has_dep1                      = w1[32];
    new_entry.has_dep2                      = w2[32];
    new_entry.constrt1[ROB_WIDTH-1:0]       = add_constrt1_i;
    new_entry.constrt2[ROB_WIDTH-1:0]       = add_constrt2_i;
`ifdef RS_AGE_ISSUE_EN
    new_entry.stamp[StampW-1:0]             = seq_q;
`endif
  end

  always_comb begin
    logic [32:0] w1, w2;
    w1 = '0;
    w2 = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      entry_d[i]          = entry_q[i];
      w1 = wake(entry_q[i].has_dep1, entry_q[i].constrt1[ROB_WIDTH-1:0], entry_q[i].value1);
      w2 = wake(entry_q[i].has_dep2, entry_q[i].constrt2[ROB_WIDTH-1:0], entry_q[i].value2);
      entry_d[i].has_dep1 = w1[32];
      entry_d[i].value1   = w1[31:0];
      entry_d[i].has_dep2 = w2[32];
      entry_d[i].value2   = w2[31:0];
    end
    if (do_issue)  entry_d[sel_idx].valid = 1'b0;
    if (do_insert) entry_d[free_idx] = new_entry;
    if (flush_i) begin
      for (int i = 0; i < int'(Depth); i++) entry_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    occ_d = flush_i ? '0 : occ_q + OccW'(do_insert) - OccW'(do_issue);
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_v1_d    = ex_v1_q;
    ex_v2_d    = ex_v2_q;
    ex_rob_d   = ex_rob_q;
    wb_valid_d = wb_valid_q;
    wb_rob_d   = wb_rob_q;
    wb_val_d   = wb_val_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      wb_valid_d = 1'b0;
    end else begin
      if (ex_free) begin
        ex_valid_d = do_issue;
        ex_op_d    = entry_q[sel_idx].op;
        ex_v1_d    = entry_q[sel_idx].value1;
        ex_v2_d    = entry_q[sel_idx].value2;
        ex_rob_d   = entry_q[sel_idx].rob_index[ROB_WIDTH-1:0];
      end
      if (wb_free) begin
        wb_valid_d = ex_valid_q;
        wb_rob_d   = ex_rob_q;
        wb_val_d   = alu_result;
      end
    end
  end

  rs_alu #(
    .RS_OP_WIDTH(RS_OP_WIDTH)
  ) u_alu (
    .op_i    (ex_op_q),
    .v1_i    (ex_v1_q),
    .v2_i    (ex_v2_q),
    .result_o(alu_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) entry_q[i] <= '0;
      occ_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_v1_q    <= '0;
      ex_v2_q    <= '0;
      ex_rob_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rob_q   <= '0;
      wb_val_q   <= '0;
    end else begin
      entry_q    <= entry_d;
      occ_q      <= occ_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_v1_q    <= ex_v1_d;
      ex_v2_q    <= ex_v2_d;
      ex_rob_q   <= ex_rob_d;
      wb_valid_q <= wb_valid_d;
      wb_rob_q   <= wb_rob_d;
      wb_val_q   <= wb_val_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with an in-order result scoreboard.
module tb_alu_reservation_station;
  import rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, add_valid, add_d1, add_d2, full, upd_valid, upd_ready;
  logic [3:0]  add_op, add_rob, add_c1, add_c2, upd_rob;
  logic [31:0] add_v1, add_v2, upd_val;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob;
  logic [63:0] cdb_val;

  int          checks = 0;
  int          failures = 0;
  logic [35:0] sb[$];
  logic [35:0] mon_exp;

  initial forever #5 clk = ~clk;

  alu_reservation_station #(
    .RS_OP_WIDTH(4),
    .RS_WIDTH   (4),
    .ROB_WIDTH  (4),
    .CDB_PORTS  (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .add_valid_i    (add_valid),
    .add_op_i       (add_op),
    .add_rob_index_i(add_rob),
    .add_val1_i     (add_v1),
    .add_val2_i     (add_v2),
    .add_has_dep1_i (add_d1),
    .add_has_dep2_i (add_d2),
    .add_constrt1_i (add_c1),
    .add_constrt2_i (add_c2),
    .full_o         (full),
    .cdb_valid_i    (cdb_valid),
    .cdb_rob_id_i   (cdb_rob),
    .cdb_val_i      (cdb_val),
    .update_valid_o (upd_valid),
    .update_ready_i (upd_ready),
    .update_rob_id_o(upd_rob),
    .update_val_o   (upd_val)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ins(input logic [3:0] op, input logic [3:0] tag, input logic [31:0] v1,
                     input logic [31:0] v2, input logic d1, input logic d2,
                     input logic [3:0] c1, input logic [3:0] c2);
    add_valid = 1'b1;
    add_op = op; add_rob = tag; add_v1 = v1; add_v2 = v2;
    add_d1 = d1; add_d2 = d2; add_c1 = c1; add_c2 = c2;
    tick();
    add_valid = 1'b0;
  endtask

  task automatic cdb(input int p, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[p]       = 1'b1;
    cdb_rob[p*4 +: 4]  = tag;
    cdb_val[p*32 +: 32] = val;
  endtask

  task automatic cdb_clr();
    cdb_valid = '0;
  endtask

  // Result must appear exactly two edges after the edge that made it ready.
  task automatic expect_latency(input string tag);
    smp(); chk({tag, "_lat0"}, 36'(upd_valid), 36'd0);
    tick(); smp(); chk({tag, "_lat1"}, 36'(upd_valid), 36'd0);
    tick(); smp(); chk({tag, "_lat2"}, 36'(upd_valid), 36'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk(tag, 36'(sb.size()), 36'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; add_valid = 1'b0; upd_ready = 1'b1;
    add_op = '0; add_rob = '0; add_v1 = '0; add_v2 = '0;
    add_d1 = 1'b0; add_d2 = 1'b0; add_c1 = '0; add_c2 = '0;
    cdb_valid = '0; cdb_rob = '0; cdb_val = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && upd_valid && upd_ready) begin
          checks++;
          assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_result observed=%0h_%0h expected=none", upd_rob, upd_val);
          end
          if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            chk("result", {upd_rob, upd_val}, mon_exp);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    smp();
    chk("rst_full", 36'(full), 36'd0);
    chk("rst_uvalid", 36'(upd_valid), 36'd0);
    chk("rst_urob", 36'(upd_rob), 36'd0);
    chk("rst_uval", 36'(upd_val), 36'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // Independent ADD
    ins(OpAdd, 4'd3, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd3, 32'd12});
    expect_latency("add");
    drain("drain_add");

    // CDB wakeup one cycle after insert, then in the insert cycle
    ins(OpSub, 4'd5, 32'd0, 32'd1, 1'b1, 1'b0, 4'd9, 4'd0);
    sb.push_back({4'd5, 32'd99});
    cdb(1, 4'd9, 32'd100);
    tick();
    cdb_clr();
    expect_latency("sub_late");
    drain("drain_sub_late");

    cdb(1, 4'd9, 32'd100);
    ins(OpSub, 4'd6, 32'd0, 32'd1, 1'b1, 1'b0, 4'd9, 4'd0);
    cdb_clr();
    sb.push_back({4'd6, 32'd99});
    expect_latency("sub_same");
    drain("drain_sub_same");

    // Two ports match the same tag: lowest port wins
    cdb(0, 4'd10, 32'd11);
    cdb(1, 4'd10, 32'd22);
    ins(OpAdd, 4'd7, 32'd0, 32'd0, 1'b1, 1'b1, 4'd10, 4'd10);
    cdb_clr();
    sb.push_back({4'd7, 32'd22});
    expect_latency("port_prio");
    drain("drain_prio");

    // Self-port wakeup chain
    ins(OpAdd, 4'd1, 32'd2, 32'd3, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd1, 32'd5});
    ins(OpAnd, 4'd2, 32'd0, 32'd6, 1'b1, 1'b0, 4'd1, 4'd0);
    sb.push_back({4'd2, 32'd4});
    drain("drain_chain");

    // Backpressure with four ready entries
    upd_ready = 1'b0;
    ins(OpAdd, 4'd4, 32'd10, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd4, 32'd11});
    ins(OpAdd, 4'd5, 32'd20, 32'd2, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd5, 32'd22});
    ins(OpOr, 4'd6, 32'h30, 32'h3, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd6, 32'h33});
    ins(OpXor, 4'd7, 32'hF0, 32'hFF, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd7, 32'h0F});
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("stall_valid", 36'(upd_valid), 36'd1);
      chk("stall_hold", {upd_rob, upd_val}, {4'd4, 32'd11});
      tick();
    end
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("release_b2b", 36'(upd_valid), 36'd1);
      tick();
    end
    smp();
    chk("release_done", 36'(upd_valid), 36'd0);
    drain("drain_stall");

    // Fill with never-ready entries, overflow attempt, then flush
    for (int i = 0; i < 16; i++) begin
      ins(OpAdd, 4'(i), 32'd0, 32'd0, 1'b1, 1'b1, 4'd15, 4'd15);
      if (i == 14) begin
        smp();
        chk("not_full_15", 36'(full), 36'd0);
      end
    end
    smp();
    chk("full_16", 36'(full), 36'd1);
    ins(OpAdd, 4'd12, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    smp();
    chk("full_after_17th", 36'(full), 36'd1);
    repeat (4) tick();
    flush = 1'b1;
    add_valid = 1'b1;
    add_rob = 4'd13; add_d1 = 1'b0; add_d2 = 1'b0;
    cdb(0, 4'd15, 32'd5);
    tick();
    flush = 1'b0; add_valid = 1'b0;
    cdb_clr();
    smp();
    chk("flush_full", 36'(full), 36'd0);
    chk("flush_uvalid", 36'(upd_valid), 36'd0);
    cdb(0, 4'd15, 32'd5);
    repeat (3) tick();
    cdb_clr();
    repeat (8) tick();
    smp();
    chk("flush_quiet", 36'(upd_valid), 36'd0);
    ins(OpAdd, 4'd8, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd8, 32'd2});
    expect_latency("post_flush");
    drain("drain_flush");

    // ALU corner cases, back to back
    ins(OpSra, 4'd1, 32'h8000_0000, 32'd33, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd1, 32'hC000_0000});
    ins(OpLt, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd2, 32'd1});
    ins(OpLtu, 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd3, 32'd0});
    ins(OpSll, 4'd4, 32'd1, 32'd36, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd4, 32'h10});
    ins(OpSrl, 4'd5, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd5, 32'h0800_0000});
    ins(OpEq, 4'd6, 32'd5, 32'd5, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd6, 32'd1});
    ins(OpNe, 4'd7, 32'd5, 32'd5, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd7, 32'd0});
    ins(OpSub, 4'd8, 32'd3, 32'd5, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd8, 32'hFFFF_FFFE});
    ins(4'd12, 4'd9, 32'd7, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd9, 32'd0});
    drain("drain_alu");

    // Asynchronous reset while a result is held
    upd_ready = 1'b0;
    ins(OpAdd, 4'd9, 32'd1, 32'd2, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd9, 32'd3});
    tick();
    tick();
    smp();
    chk("pre_reset_valid", 36'(upd_valid), 36'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_uvalid", 36'(upd_valid), 36'd0);
    chk("mid_reset_out", {upd_rob, upd_val}, 36'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    upd_ready = 1'b1;
    ins(OpAdd, 4'd2, 32'd4, 32'd4, 1'b0, 1'b0, 4'd0, 4'd0);
    sb.push_back({4'd2, 32'd8});
    expect_latency("post_reset");
    drain("drain_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
